// File: rtl/registro_desplazable_c.sv
// Behavioural 32-bit universal shift register: hold, shift, rotate, load.
// Optional even-parity output PAR enabled by macro REGISTRO_PARIDAD_EN.
module registro_desplazable_c #(
  parameter int ANCHO = 32,
  parameter int CW    = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic [ANCHO-1:0] D,
  output logic [ANCHO-1:0] Q,
  output logic             S_OUT,
  output logic [CW-1:0]    CUENTA,
`ifdef REGISTRO_PARIDAD_EN
  output logic             PAR,
`endif
  output logic             FIN
);

  localparam logic [CW-1:0] CMAX = CW'(ANCHO);
  localparam logic [CW-1:0] CPRE = CW'(ANCHO - 1);

  logic [ANCHO-1:0] q_n;
  logic             sout_n;
  logic [CW-1:0]    cnt_n;
  logic             fin_n;
  logic             mover;

  always_comb begin
    q_n    = Q;
    sout_n = S_OUT;
    cnt_n  = CUENTA;
    fin_n  = 1'b0;
    mover  = 1'b0;
    if (ENB) begin
      unique case (MODO)
        2'b01: begin
          mover = 1'b1;
          if (DIR) begin
            q_n    = {S_IN, Q[ANCHO-1:1]};
            sout_n = Q[0];
          end else begin
            q_n    = {Q[ANCHO-2:0], S_IN};
            sout_n = Q[ANCHO-1];
          end
        end
        2'b10: begin
          mover = 1'b1;
          if (DIR) begin
            q_n    = {Q[0], Q[ANCHO-1:1]};
            sout_n = Q[0];
          end else begin
            q_n    = {Q[ANCHO-2:0], Q[ANCHO-1]};
            sout_n = Q[ANCHO-1];
          end
        end
        2'b11: begin
          q_n    = D;
          sout_n = 1'b0;
          cnt_n  = '0;
        end
        default: ;
      endcase
    end
    // Count saturates at ANCHO; FIN marks only the entry into saturation
    if (mover && CUENTA != CMAX) begin
      cnt_n = CUENTA + 1'b1;
      fin_n = (CUENTA == CPRE);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q      <= '0;
      S_OUT  <= 1'b0;
      CUENTA <= '0;
      FIN    <= 1'b0;
    end else begin
      Q      <= q_n;
      S_OUT  <= sout_n;
      CUENTA <= cnt_n;
      FIN    <= fin_n;
    end
  end

`ifdef REGISTRO_PARIDAD_EN
  always_ff @(posedge CLK) begin
    if (RESET) PAR <= 1'b0;
    else if (ENB) PAR <= ^q_n;
  end
`endif

endmodule

// File: doc/registro_desplazable_c.md
Name: registro_desplazable_c

Overview:
- Behavioural-description 32-bit universal shift register.
- Its Q is the conductual reference (Qc) consumed by the downstream structural-vs-behavioural comparator. The structural twin receives identical stimulus and drives Qe.
- Supports hold, serial shift, rotate and parallel load. Tracks shifts since the last load and pulses FIN once a full word has been shifted out.
- Q updates at the CLK rising edge with no added delay. Q is stable well before the comparator's 48 ns post-edge sample point.

Parameters:
- ANCHO, 32, register width in bits (comparator expects 32).
- CW, 6, width of CUENTA; must satisfy 2^CW > ANCHO.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset; sampled on CLK rising edge.
- ENB  input  1  clock enable; low = hold all state.
- MODO  input  2  00 hold, 01 shift, 10 rotate, 11 parallel load.
- DIR  input  1  0 = left (toward MSB), 1 = right (toward LSB).
- S_IN  input  1  serial input bit for shift mode.
- D  input  ANCHO  parallel load data.
- Q  output  ANCHO  register contents (to comparator Qc).
- S_OUT  output  1  registered bit that left the register on the last shift/rotate.
- CUENTA  output  CW  shifts/rotates since last load or reset, saturating.
- FIN  output  1  one-cycle pulse when CUENTA reaches ANCHO.

Behaviour:
- All outputs registered; one-cycle latency from inputs to outputs.
- Reset (RESET=1 at edge): Q=0, S_OUT=0, CUENTA=0, FIN=0. Overrides ENB and MODO. Mid-operation reset discards contents and count immediately.
- ENB=0: Q, S_OUT and CUENTA hold; FIN forced 0.
- ENB=1, MODO=00: Q, S_OUT and CUENTA hold; FIN=0.
- ENB=1, MODO=01, DIR=0: Q<={Q[ANCHO-2:0],S_IN}; S_OUT<=Q[ANCHO-1].
- ENB=1, MODO=01, DIR=1: Q<={S_IN,Q[ANCHO-1:1]}; S_OUT<=Q[0].
- ENB=1, MODO=10, DIR=0: Q<={Q[ANCHO-2:0],Q[ANCHO-1]}; S_OUT<=Q[ANCHO-1].
- ENB=1, MODO=10, DIR=1: Q<={Q[0],Q[ANCHO-1:1]}; S_OUT<=Q[0]. S_IN is ignored in rotate.
- ENB=1, MODO=11: Q<=D; S_OUT<=0; CUENTA<=0; FIN<=0. DIR and S_IN are ignored.
- CUENTA increments by 1 on every shift or rotate edge and saturates at ANCHO. No wrap-around; further shifts keep it at ANCHO.
- FIN=1 for exactly the one cycle in which CUENTA transitions ANCHO-1 -> ANCHO; 0 otherwise, including while saturated.
- DIR may change between any two shifts; the count continues regardless of direction.
- Load on the same edge as a would-be shift: load wins, since MODO is exclusive.

Optional Feature:
- Macro REGISTRO_PARIDAD_EN.
- Defined: adds output PAR (1 bit), registered even parity of the next Q (PAR == ^Q after every edge), reset to 0, held when ENB=0.
- Undefined: no PAR port and no parity logic; all other behaviour identical.

Test Plan:
- Reset: RESET=1 for 2 edges with D=32'hFFFFFFFF, MODO=11, ENB=1 -> Q=0, S_OUT=0, CUENTA=0, FIN=0.
- Load then hold: MODO=11, D=32'hA5A5_0F0F; next edge MODO=00 for 3 edges -> Q=32'hA5A5_0F0F throughout, CUENTA=0. Same value with ENB=0 and MODO=01 -> unchanged.
- Shift left:
  - Load 32'h8000_0001, then MODO=01, DIR=0, S_IN=1 for 1 edge -> Q=32'h0000_0003, S_OUT=1, CUENTA=1.
  - Continue 31 more edges -> CUENTA=32, FIN=1 on that edge only, Q=32'hFFFF_FFFF.
  - One more edge -> CUENTA stays 32, FIN=0.
- Shift/rotate right:
  - Load 32'h0000_0001, MODO=10, DIR=1 for 1 edge -> Q=32'h8000_0000, S_OUT=1.
  - Then MODO=01, DIR=1, S_IN=0 -> Q=32'h4000_0000, S_OUT=0, CUENTA=2.
- Reset mid-shift: after 10 shift edges (CUENTA=10), assert RESET one edge while MODO=01 -> Q=0, CUENTA=0, FIN never pulses.
- Comparator pairing: drive this block and the structural twin with the same random MODO/DIR/S_IN/D for 1000 cycles -> comparator ALERTA stays 0 at every 48 ns sample.
